intersection_monitor: RTL and testbench
=======================================

// Module: intersection_monitor
// PURPOSE
//   Synthesizable runtime safety/liveness monitor for an N-channel intersection controller.
//   - Checks that conflicting channels are never green together.
//   - Checks that every request is served with green within MAX_WAIT cycles.
//   - Errors are sticky; the first error is captured with channel, type and cycle stamp.
//   - Sits beside the intersection top level and taps its request and green lines.
// PARAMETERS
//   NUM_CH        4       number of channels (ch0 ped, ch1 up, ch2 down, ch3 turn)
//   MAX_WAIT      25      last cycle, counted from the request cycle, at which green is still legal
//   CONFLICT      16'h4916  NUM_CH*NUM_CH mask; bit i*NUM_CH+j = 1 -> ch i and ch j conflict
//                         (default: ped/up, ped/down, down/turn; must be symmetric, diagonal 0)
//   STAMP_W       32      width of the cycle stamp
// PORTS
//   clock            in   1        single clock; all logic on posedge
//   reset            in   1        synchronous, active-high
//   req              in   NUM_CH   per-channel service request (button/sensor), level or pulse
//   green            in   NUM_CH   per-channel green from the controller
//   live_err         out  NUM_CH   sticky: channel missed its MAX_WAIT deadline
//   conf_err         out  1        sticky: a conflicting pair was green together
//   any_err          out  1        OR of conf_err and all live_err bits (registered)
//   first_err_valid  out  1        first error captured
//   first_err_type   out  1        0 = conflict, 1 = liveness
//   first_err_ch     out  $clog2(NUM_CH)  channel of the first error
//   first_err_stamp  out  STAMP_W  cycle count at detection
// BEHAVIOUR
//   Reset: all outputs 0, pending/wait/stamp cleared. No checks are active while reset=1.
//   stamp: increments every cycle after reset; saturates at all-ones and does not wrap.
//   Per channel i, evaluated in priority order each cycle:
//     green[i]                -> pending<=0, wait<=0. A req in the same cycle is served.
//     pending && wait==MAX_WAIT -> live_err[i]<=1, pending<=0.
//     pending                 -> wait<=wait+1. A new req does not restart the oldest request.
//     req[i]                  -> pending<=1, wait<=1.
//   Timing: req at cycle 0 and green at cycle k, 0..MAX_WAIT -> no error.
//     Without green by MAX_WAIT, live_err rises at cycle MAX_WAIT+1.
//   Conflict: if any (i,j) has CONFLICT bit set and green[i]&green[j] -> conf_err<=1 next cycle.
//   First-error capture (only while first_err_valid==0):
//     - Conflict beats liveness when both occur in the same cycle.
//     - Conflict channel = lowest i of any violating pair.
//     - Liveness channel = lowest i hitting its deadline.
//     - stamp = stamp value of the detecting cycle.
//   Latency: every error output is registered, 1 cycle after the violating input sample.
//   Reset mid-operation clears everything, including sticky flags and in-flight waits.
//   wait counter width: $clog2(MAX_WAIT+1). It never exceeds MAX_WAIT.
// CONFIGURATION
//   INTERSECTION_MONITOR_STATS_EN defined:
//     - Adds output max_wait [NUM_CH*$clog2(MAX_WAIT+1)].
//     - Per channel, holds the largest wait seen when green serves a pending request.
//     - Reset to 0. It does not update on a liveness failure.
//   Not defined: port and logic absent; all other behaviour identical.
// STRUCTURE
//   intersection_pkg: err_type_e (ERR_CONFLICT=0, ERR_LIVENESS=1), default CONFLICT constant,
//     and a function returning the lowest set index.
//   Sub-module intersection_chan_timer:
//     - One instance per channel (generate loop).
//     - Holds pending, wait, live_err and the optional max_wait.
//     - Outputs a deadline pulse to the top level.
//   Top level: conflict-pair reduction, priority select, first-error capture, stamp counter.
// TESTING
//   1. req[0] pulse at cycle 10, green[0] at cycle 35 -> no error (k=25 is legal).
//   2. req[0] pulse at cycle 10, no green -> live_err=4'b0001 at cycle 36; first_err type=1, ch=0.
//   3. green=4'b0011 for one cycle at cycle 50 -> next cycle: conf_err=1, first_err type=0,
//      ch=0, stamp=50.
//   4. Same cycle: green=4'b1100 (conflict) and ch1 hits its deadline -> first_err type=0, ch=2.
//      live_err[1] is still set.
//   5. req[3] held high, green[3] never asserted -> live_err[3] rises once.
//      pending is then re-armed by the still-high req. No false error on ch0..2.
//   6. Reset asserted at wait=20 on ch1 -> all outputs 0. No live_err after reset is released.
//      With STATS_EN: after green serves at wait=7, max_wait[ch1]=7.

Source files
------------

// File: rtl/intersection_pkg.sv
// intersection_pkg
//   Shared types and constants for the intersection safety/liveness monitor.
//   - err_type_e       : first-error classification (conflict or liveness)
//   - DEFAULT_CONFLICT : default 4-channel conflict matrix
//                        (ped/up, ped/down, down/turn; symmetric, zero diagonal)
//   - lowest_set()     : index of the lowest set bit of a vector (0 if none)
package intersection_pkg;

  typedef enum logic {
    ERR_CONFLICT = 1'b0,
    ERR_LIVENESS = 1'b1
  } err_type_e;

  localparam logic [15:0] DEFAULT_CONFLICT = 16'h4916;

  // Scans from the top down so the last hit, which is the lowest index, wins.
  function automatic int lowest_set(input logic [31:0] vec);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/intersection_chan_timer.sv
// intersection_chan_timer
//   Per-channel liveness timer. Tracks the oldest outstanding request and
//   flags a sticky live_err when green has not arrived by MAX_WAIT cycles
//   after the request cycle.
//   Optional feature macro: INTERSECTION_MONITOR_STATS_EN (adds max_wait).
// Ports
//   clock     in   1       clock, posedge
//   reset     in   1       synchronous, active-high
//   req       in   1       service request (level or pulse)
//   green     in   1       green from the controller
//   deadline  out  1       combinational: this cycle is the missed deadline
//   live_err  out  1       sticky deadline-missed flag
//   max_wait  out  WAIT_W  largest wait served by green (STATS_EN only)
module intersection_chan_timer #(
  parameter int MAX_WAIT = 25,
  parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              green,
`ifdef INTERSECTION_MONITOR_STATS_EN
  output logic [WAIT_W-1:0] max_wait,
`endif
  output logic              deadline,
  output logic              live_err
);

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT);

  logic              pending;
  logic [WAIT_W-1:0] wait_cnt;

  // Green has priority: a green in the deadline cycle still serves the request.
  always_comb begin
    deadline = pending && (wait_cnt == LAST_WAIT) && !green;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending  <= 1'b0;
      wait_cnt <= '0;
      live_err <= 1'b0;
`ifdef INTERSECTION_MONITOR_STATS_EN
      max_wait <= '0;
`endif
    end else if (green) begin
`ifdef INTERSECTION_MONITOR_STATS_EN
      if (pending && (wait_cnt > max_wait)) max_wait <= wait_cnt;
`endif
      pending  <= 1'b0;
      wait_cnt <= '0;
    end else if (pending && (wait_cnt == LAST_WAIT)) begin
      // Drop the request; a still-high req re-arms it on the next cycle.
      live_err <= 1'b1;
      pending  <= 1'b0;
      wait_cnt <= '0;
    end else if (pending) begin
      // Further requests while pending do not restart the oldest one.
      wait_cnt <= wait_cnt + 1'b1;
    end else if (req) begin
      pending  <= 1'b1;
      wait_cnt <= WAIT_W'(1);
    end
  end

endmodule

// File: rtl/intersection_monitor.sv
// intersection_monitor
//   Runtime safety/liveness monitor for an N-channel intersection controller.
//   Flags conflicting greens, per-channel missed service deadlines, and
//   captures the first error with its type, channel and cycle stamp.
//   Optional feature macro: INTERSECTION_MONITOR_STATS_EN (adds max_wait).
// Ports
//   clock            in   1              clock, posedge
//   reset            in   1              synchronous, active-high
//   req              in   NUM_CH         per-channel service request
//   green            in   NUM_CH         per-channel green
//   live_err         out  NUM_CH         sticky missed-deadline flags
//   conf_err         out  1              sticky conflicting-green flag
//   any_err          out  1              OR of all error flags (registered)
//   first_err_valid  out  1              first error captured
//   first_err_type   out  1              0 = conflict, 1 = liveness
//   first_err_ch     out  CH_W           channel of the first error
//   first_err_stamp  out  STAMP_W        cycle stamp of the detecting cycle
//   max_wait         out  NUM_CH*WAIT_W  per-channel largest served wait (STATS_EN only)
module intersection_monitor
  import intersection_pkg::*;
#(
  parameter int                         NUM_CH   = 4,
  parameter int                         MAX_WAIT = 25,
  parameter logic [NUM_CH*NUM_CH-1:0]   CONFLICT = DEFAULT_CONFLICT,
  parameter int                         STAMP_W  = 32,
  localparam int                        CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int                        WAIT_W   = $clog2(MAX_WAIT + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          req,
  input  logic [NUM_CH-1:0]          green,
`ifdef INTERSECTION_MONITOR_STATS_EN
  output logic [NUM_CH*WAIT_W-1:0]   max_wait,
`endif
  output logic [NUM_CH-1:0]          live_err,
  output logic                       conf_err,
  output logic                       any_err,
  output logic                       first_err_valid,
  output logic                       first_err_type,
  output logic [CH_W-1:0]            first_err_ch,
  output logic [STAMP_W-1:0]         first_err_stamp
);

  logic [NUM_CH-1:0]  deadline;
  logic [NUM_CH-1:0]  conf_vec;
  logic               conf_hit;
  logic               live_hit;
  logic [STAMP_W-1:0] stamp;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    intersection_chan_timer #(
      .MAX_WAIT (MAX_WAIT),
      .WAIT_W   (WAIT_W)
    ) u_timer (
      .clock    (clock),
      .reset    (reset),
      .req      (req[g]),
      .green    (green[g]),
`ifdef INTERSECTION_MONITOR_STATS_EN
      .max_wait (max_wait[g*WAIT_W +: WAIT_W]),
`endif
      .deadline (deadline[g]),
      .live_err (live_err[g])
    );
  end

  // Mark both members of every violating pair; the lowest marked index is
  // then the lowest i of any violating pair.
  always_comb begin
    conf_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (CONFLICT[i*NUM_CH+j] && green[i] && green[j]) begin
          conf_vec[i] = 1'b1;
          conf_vec[j] = 1'b1;
        end
      end
    end
    conf_hit = |conf_vec;
    live_hit = |deadline;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stamp           <= '0;
      conf_err        <= 1'b0;
      any_err         <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_type  <= ERR_CONFLICT;
      first_err_ch    <= '0;
      first_err_stamp <= '0;
    end else begin
      if (stamp != '1) stamp <= stamp + 1'b1;
      if (conf_hit) conf_err <= 1'b1;
      if (conf_hit || live_hit) any_err <= 1'b1;
      if (!first_err_valid && (conf_hit || live_hit)) begin
        first_err_valid <= 1'b1;
        first_err_stamp <= stamp;
        // Conflict wins over a liveness failure in the same cycle.
        if (conf_hit) begin
          first_err_type <= ERR_CONFLICT;
          first_err_ch   <= CH_W'(lowest_set(32'(conf_vec)));
        end else begin
          first_err_type <= ERR_LIVENESS;
          first_err_ch   <= CH_W'(lowest_set(32'(deadline)));
        end
      end
    end
  end

endmodule

// File: tb/tb_intersection_monitor.sv
// tb_intersection_monitor
//   Self-checking bench for intersection_monitor (default parameters).
//   Optional feature macro: INTERSECTION_MONITOR_STATS_EN (checks max_wait).
//   Cycle numbering: cycle 0 is the first cycle with reset low. tick() applies
//   one cycle of inputs; outputs checked after tick(c) belong to cycle c+1.
module tb_intersection_monitor;

  localparam int WAIT_W = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req   = '0;
  logic [3:0]  green = '0;
  logic [3:0]  live_err;
  logic        conf_err;
  logic        any_err;
  logic        first_err_valid;
  logic        first_err_type;
  logic [1:0]  first_err_ch;
  logic [31:0] first_err_stamp;
`ifdef INTERSECTION_MONITOR_STATS_EN
  logic [4*WAIT_W-1:0] max_wait;
`endif

  int checks = 0;
  int passes = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  intersection_monitor dut (
    .clock           (clock),
    .reset           (reset),
    .req             (req),
    .green           (green),
`ifdef INTERSECTION_MONITOR_STATS_EN
    .max_wait        (max_wait),
`endif
    .live_err        (live_err),
    .conf_err        (conf_err),
    .any_err         (any_err),
    .first_err_valid (first_err_valid),
    .first_err_type  (first_err_type),
    .first_err_ch    (first_err_ch),
    .first_err_stamp (first_err_stamp)
  );

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    green = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic tick(input logic [3:0] r, input logic [3:0] g);
    req   = r;
    green = g;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(4'b0000, 4'b0000);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [3:0] el, input logic ec,
                       input logic ea, input logic ev, input logic et,
                       input logic [1:0] ech, input logic [31:0] es);
    logic [42:0] got, exp;
    got = {live_err, conf_err, any_err, first_err_valid, first_err_type,
           first_err_ch, first_err_stamp};
    exp = {el, ec, ea, ev, et, ech, es};
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got live=%b conf=%b any=%b valid=%b type=%b ch=%0d stamp=%0d, expected live=%b conf=%b any=%b valid=%b type=%b ch=%0d stamp=%0d",
                  name, live_err, conf_err, any_err, first_err_valid, first_err_type,
                  first_err_ch, first_err_stamp, el, ec, ea, ev, et, ech, es);
  endtask

  task automatic check_clear(input string name);
    check(name, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

`ifdef INTERSECTION_MONITOR_STATS_EN
  task automatic check_max(input string name, input int ch, input logic [WAIT_W-1:0] exp);
    logic [WAIT_W-1:0] got;
    got = max_wait[ch*WAIT_W +: WAIT_W];
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: max_wait[%0d] got %0d expected %0d", name, ch, got, exp);
  endtask
`endif

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  green;
    logic [3:0]  exp_live;
    logic        exp_conf;
    logic        exp_any;
    logic        exp_valid;
    logic        exp_type;
    logic [1:0]  exp_ch;
    logic [31:0] exp_stamp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // ---------------- table: conflict matrix from fresh reset ----------------
    tbl[0] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0};
    tbl[1] = '{4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0};
    tbl[2] = '{4'b0000, 4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0};
    tbl[3] = '{4'b0000, 4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0};
    tbl[4] = '{4'b0000, 4'b1001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0};
    tbl[5] = '{4'b0000, 4'b0101, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'd5};
    tbl[6] = '{4'b0000, 4'b1100, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'd5};
    tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'd5};

    do_reset();
    check_clear("reset_state");
    for (int r = 0; r < 8; r++) begin
      tick(tbl[r].req, tbl[r].green);
      check($sformatf("table_row%0d", r), tbl[r].exp_live, tbl[r].exp_conf, tbl[r].exp_any,
            tbl[r].exp_valid, tbl[r].exp_type, tbl[r].exp_ch, tbl[r].exp_stamp);
    end

    // ---------------- 1: green exactly at the deadline is legal ----------------
    do_reset();
    idle(10);
    tick(4'b0001, 4'b0000);               // cycle 10
    idle(24);                             // cycles 11..34
    check_clear("t1_before_green");
    tick(4'b0000, 4'b0001);               // cycle 35, wait == 25
    check_clear("t1_at_green");
    idle(30);
    check_clear("t1_long_after");

    // ---------------- 2: missed deadline on ch0 ----------------
    do_reset();
    idle(10);
    tick(4'b0001, 4'b0000);               // cycle 10
    idle(24);                             // cycles 11..34
    check_clear("t2_cycle35");
    tick(4'b0000, 4'b0000);               // cycle 35 detects
    check("t2_cycle36", 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 32'd35);
    idle(5);
    check("t2_sticky", 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 32'd35);

    // ---------------- 3: ped/up conflict at cycle 50 ----------------
    do_reset();
    idle(50);
    check_clear("t3_before");
    tick(4'b0000, 4'b0011);               // cycle 50
    check("t3_conflict", 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'd50);
    idle(3);
    check("t3_sticky", 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'd50);

    // ---------------- 4: conflict beats same-cycle liveness ----------------
    do_reset();
    tick(4'b0010, 4'b0000);               // cycle 0: req ch1
    idle(24);                             // cycles 1..24
    check_clear("t4_before");
    tick(4'b0000, 4'b1100);               // cycle 25: ch1 deadline + down/turn
    check("t4_both", 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 32'd25);

    // ---------------- 5: held request, never served ----------------
    do_reset();
    for (int c = 0; c < 25; c++) tick(4'b1000, 4'b0000);   // cycles 0..24
    check_clear("t5_before");
    tick(4'b1000, 4'b0000);               // cycle 25 detects
    check("t5_first", 4'b1000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 32'd25);
    for (int c = 26; c < 60; c++) tick(4'b1000, 4'b0000);  // re-armed deadline at 51
    check("t5_rearmed", 4'b1000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 32'd25);
    tick(4'b0000, 4'b1000);               // serve the re-armed request
    idle(30);
    check("t5_served", 4'b1000, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 32'd25);

    // ---------------- 6: reset mid-wait clears everything ----------------
    do_reset();
    tick(4'b0010, 4'b0000);               // cycle 0: req ch1
    idle(6);                              // cycles 1..6
    tick(4'b0000, 4'b0010);               // cycle 7: served at wait 7
    check_clear("t6_served");
`ifdef INTERSECTION_MONITOR_STATS_EN
    check_max("t6_max_wait7", 1, 5'd7);
    check_max("t6_max_ch0", 0, 5'd0);
`endif
    tick(4'b0010, 4'b0000);               // cycle 8: req ch1
    idle(20);                             // wait == 20 in cycle 28
    do_reset();
    check_clear("t6_after_reset");
`ifdef INTERSECTION_MONITOR_STATS_EN
    check_max("t6_max_cleared", 1, 5'd0);
`endif
    idle(40);
    check_clear("t6_no_late_err");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
